instr_issue_unit: RTL and testbench

//  Fetch/decode/issue front end that drives the 4-stage register-ALU pipeline.

---
 rtl/instr_issue_unit_if.sv | 36 +++
 rtl/instr_issue_unit.sv | 172 +++++++++++++++++
 tb/tb_instr_issue_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issue_unit_if.sv
// Instruction-issue bus bundle.
// Groups the instruction ROM read port and the decoded issue bundle that
// feeds pipeline stage 1.
//   imem_en     - ROM read enable (issue unit -> ROM)
//   imem_addr   - ROM read address, PC_W bits (issue unit -> ROM)
//   imem_rdata  - 24-bit ROM word, valid the cycle after imem_en (ROM -> issue unit)
//   issue_valid - issue_* fields carry a real instruction
//   issue_func  - word[23:20], 4'hF marks a bubble
//   issue_rd    - word[19:16]
//   issue_rs1   - word[15:12]
//   issue_rs2   - word[11:8]
//   issue_addr  - word[7:0]
// master: the issue unit. slave: the ROM / pipeline side.
interface instr_issue_unit_if #(parameter int PC_W = 8);
   logic            imem_en;
   logic [PC_W-1:0] imem_addr;
   logic [23:0]     imem_rdata;
   logic            issue_valid;
   logic [3:0]      issue_func;
   logic [3:0]      issue_rd;
   logic [3:0]      issue_rs1;
   logic [3:0]      issue_rs2;
   logic [7:0]      issue_addr;

   modport master (
      output imem_en, imem_addr,
      input  imem_rdata,
      output issue_valid, issue_func, issue_rd, issue_rs1, issue_rs2, issue_addr
   );

   modport slave (
      input  imem_en, imem_addr,
      output imem_rdata,
      input  issue_valid, issue_func, issue_rd, issue_rs1, issue_rs2, issue_addr
   );
endinterface

// File: rtl/instr_issue_unit.sv
// Fetch/decode/issue front end for the 4-stage register-ALU pipeline.
// Fetches 24-bit words from a synchronous instruction ROM, splits them into
// func/rd/rs1/rs2/addr, and issues one instruction per cycle unless a
// read-after-write hazard against the last HAZ_DEPTH issued writers forces a
// bubble. A word with func 4'hF halts the unit until the next start pulse.
// Ports:
//   clk1      - single clock, all state changes on posedge
//   rst_n     - asynchronous active-low reset
//   start     - 1-cycle pulse, begins execution at PC 0 from IDLE or HALT
//   bus       - instr_issue_unit_if master: ROM read port + issue bundle
//   halted    - 1 while in HALT
//   stall_cnt - saturating count of hazard bubbles since start
module instr_issue_unit #(
   parameter int PC_W      = 8,
   parameter int HAZ_DEPTH = 2
) (
   input  logic                clk1,
   input  logic                rst_n,
   input  logic                start,
   instr_issue_unit_if.master  bus,
   output logic                halted,
   output logic [15:0]         stall_cnt
);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [23:0]     ir;
   logic            ir_valid;
   logic            rd_pending;
   logic [HAZ_DEPTH-1:0] sb_valid;
   logic [3:0]      sb_rd [HAZ_DEPTH];

   logic [23:0]     cur_word;
   logic            cur_valid;
   logic [3:0]      cur_func;
   logic [3:0]      cur_rd;
   logic [3:0]      cur_rs1;
   logic [3:0]      cur_rs2;
   logic            uses_rs1;
   logic            uses_rs2;
   logic            writes_rd;
   logic            hazard;
   logic            is_halt;
   logic            do_issue;

   // The instruction under decision is the ROM word when a read returned this
   // cycle, otherwise the held copy in ir (replayed while a hazard stalls).
   assign cur_word  = rd_pending ? bus.imem_rdata : ir;
   assign cur_valid = rd_pending | ir_valid;
   assign cur_func  = cur_word[23:20];
   assign cur_rd    = cur_word[19:16];
   assign cur_rs1   = cur_word[15:12];
   assign cur_rs2   = cur_word[11:8];

   // Operand usage decode: which sources a func reads and whether it writes rd.
   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = (cur_func <= 4'h8);
      case (cur_func)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9: uses_rs1 = 1'b1;
         default:                                         uses_rs1 = 1'b0;
      endcase
      case (cur_func)
         4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7: uses_rs2 = 1'b1;
         default:                             uses_rs2 = 1'b0;
      endcase
   end

   // RAW hazard: any used source matching any valid in-flight writer.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_valid[i] && ((uses_rs1 && (cur_rs1 == sb_rd[i])) ||
                             (uses_rs2 && (cur_rs2 == sb_rd[i])))) begin
            hazard = 1'b1;
         end
      end
      if (!cur_valid) begin
         hazard = 1'b0;
      end
   end

   // The fetch decision depends on the word returned this very cycle, so the
   // ROM request is decoded combinationally; pc always names the next fetch.
   assign is_halt     = cur_valid && (cur_func == 4'hF);
   assign do_issue    = (state == RUN) && cur_valid && !is_halt && !hazard;
   assign bus.imem_en   = (state == PRIME) || do_issue;
   assign bus.imem_addr = pc;

   // Main FSM. Issue outputs default to a bubble every cycle; only func and
   // valid change on a bubble, the other fields keep their last value.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         pc              <= '0;
         ir              <= '0;
         ir_valid        <= 1'b0;
         rd_pending      <= 1'b0;
         sb_valid        <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            sb_rd[i] <= '0;
         end
         bus.issue_valid <= 1'b0;
         bus.issue_func  <= 4'hF;
         bus.issue_rd    <= '0;
         bus.issue_rs1   <= '0;
         bus.issue_rs2   <= '0;
         bus.issue_addr  <= '0;
         halted          <= 1'b0;
         stall_cnt       <= '0;
      end else begin
         rd_pending      <= bus.imem_en;
         bus.issue_valid <= 1'b0;
         bus.issue_func  <= 4'hF;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= PRIME;
                  pc        <= '0;
                  ir_valid  <= 1'b0;
                  sb_valid  <= '0;
                  stall_cnt <= '0;
               end
            end
            PRIME: begin
               pc    <= pc + 1'b1;
               state <= RUN;
            end
            RUN: begin
               ir       <= cur_word;
               ir_valid <= cur_valid;
               for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                  sb_valid[i] <= sb_valid[i-1];
                  sb_rd[i]    <= sb_rd[i-1];
               end
               sb_valid[0] <= do_issue & writes_rd;
               sb_rd[0]    <= cur_rd;
               if (is_halt) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else if (hazard) begin
                  if (stall_cnt != 16'hFFFF) begin
                     stall_cnt <= stall_cnt + 16'd1;
                  end
               end else if (do_issue) begin
                  bus.issue_valid <= 1'b1;
                  bus.issue_func  <= cur_func;
                  bus.issue_rd    <= cur_rd;
                  bus.issue_rs1   <= cur_rs1;
                  bus.issue_rs2   <= cur_rs2;
                  bus.issue_addr  <= cur_word[7:0];
                  pc              <= pc + 1'b1;
               end
            end
            HALT: begin
               if (start) begin
                  state     <= PRIME;
                  halted    <= 1'b0;
                  pc        <= '0;
                  ir_valid  <= 1'b0;
                  sb_valid  <= '0;
                  stall_cnt <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit.
// Two instances share clock and reset: dut_a (PC_W=8) for the main scenarios
// and dut_w (PC_W=2) for PC wrap-around. Each has its own synchronous ROM model.
module tb_instr_issue_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0;
   logic        start_w = 1'b0;
   logic        halted_a, halted_w;
   logic [15:0] stall_a, stall_w;
   int          total = 0;
   int          bad = 0;

   logic [23:0] rom_a [256];
   logic [23:0] rom_w [4];

   always #5 clk = ~clk;

   instr_issue_unit_if #(.PC_W(8)) bus_a ();
   instr_issue_unit_if #(.PC_W(2)) bus_w ();

   instr_issue_unit #(.PC_W(8), .HAZ_DEPTH(2)) dut_a (
      .clk1(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a),
      .halted(halted_a), .stall_cnt(stall_a)
   );

   instr_issue_unit #(.PC_W(2), .HAZ_DEPTH(2)) dut_w (
      .clk1(clk), .rst_n(rst_n), .start(start_w), .bus(bus_w),
      .halted(halted_w), .stall_cnt(stall_w)
   );

   // Synchronous ROM models: data valid the cycle after the enabled edge.
   always @(posedge clk) begin
      if (bus_a.imem_en) bus_a.imem_rdata <= rom_a[bus_a.imem_addr];
      if (bus_w.imem_en) bus_w.imem_rdata <= rom_w[bus_w.imem_addr];
   end

   // Hard stop if something hangs outside the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time exceeded, required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_a(input logic [23:0] w0, input logic [23:0] w1,
                         input logic [23:0] w2, input logic [23:0] w3,
                         input logic [23:0] w4);
      for (int i = 0; i < 256; i++) rom_a[i] = 24'hF00000;
      rom_a[0] = w0; rom_a[1] = w1; rom_a[2] = w2; rom_a[3] = w3; rom_a[4] = w4;
   endtask

   // Returns 1 ns after the edge that sampled start (start of cycle 0).
   task automatic pulse_start(input bit wrap_dut);
      @(posedge clk); #1;
      if (wrap_dut) start_w = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_w = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      load_a(24'h012300, 24'h045600, 24'h078900, 24'h0ABC00, 24'hF00000);
      pulse_start(1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (bus_a.issue_valid !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_prerun_valid: got %b required 1", bus_a.issue_valid);
      end
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (bus_a.issue_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_valid: got %b required 0", bus_a.issue_valid);
      end
      total++;
      if (bus_a.issue_func !== 4'hF) begin
         bad++; $display("[TB] FAIL reset_func: got %h required f", bus_a.issue_func);
      end
      total++;
      if ({bus_a.issue_rd, bus_a.issue_rs1, bus_a.issue_rs2, bus_a.issue_addr} !== 20'h0) begin
         bad++; $display("[TB] FAIL reset_fields: got %h required 00000",
                         {bus_a.issue_rd, bus_a.issue_rs1, bus_a.issue_rs2, bus_a.issue_addr});
      end
      total++;
      if (bus_a.imem_en !== 1'b0 || bus_a.imem_addr !== 8'h00) begin
         bad++; $display("[TB] FAIL reset_imem: got en=%b addr=%h required en=0 addr=00",
                         bus_a.imem_en, bus_a.imem_addr);
      end
      total++;
      if (halted_a !== 1'b0 || stall_a !== 16'h0) begin
         bad++; $display("[TB] FAIL reset_status: got halted=%b stall=%0d required 0/0",
                         halted_a, stall_a);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_independent();
      logic       v [8];
      logic [3:0] rd [8];
      logic [3:0] rs1 [8];
      logic       h [8];
      logic       en0;
      logic       exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      load_a(24'h012300, 24'h045600, 24'hF00000, 24'hF00000, 24'hF00000);
      pulse_start(1'b0);
      en0 = bus_a.imem_en && (bus_a.imem_addr == 8'h00);
      for (int c = 0; c < 8; c++) begin
         v[c] = bus_a.issue_valid; rd[c] = bus_a.issue_rd;
         rs1[c] = bus_a.issue_rs1; h[c] = halted_a;
         @(posedge clk); #1;
      end
      total++;
      if (en0 !== 1'b1) begin
         bad++; $display("[TB] FAIL indep_prime_fetch: got %b required 1", en0);
      end
      for (int c = 0; c < 8; c++) begin
         total++;
         if (v[c] !== exp_v[c]) begin
            bad++; $display("[TB] FAIL indep_valid_c%0d: got %b required %b", c, v[c], exp_v[c]);
         end
      end
      total++;
      if (rd[2] !== 4'h1 || rs1[2] !== 4'h2) begin
         bad++; $display("[TB] FAIL indep_first: got rd=%h rs1=%h required rd=1 rs1=2", rd[2], rs1[2]);
      end
      total++;
      if (rd[3] !== 4'h4 || rs1[3] !== 4'h5) begin
         bad++; $display("[TB] FAIL indep_second: got rd=%h rs1=%h required rd=4 rs1=5", rd[3], rs1[3]);
      end
      total++;
      if (h[5] !== 1'b1 || h[3] !== 1'b0) begin
         bad++; $display("[TB] FAIL indep_halted: got c3=%b c5=%b required 0/1", h[3], h[5]);
      end
      total++;
      if (stall_a !== 16'd0) begin
         bad++; $display("[TB] FAIL indep_stall: got %0d required 0", stall_a);
      end
   endtask

   task automatic test_raw();
      logic        v [8];
      logic [3:0]  f [8];
      logic [15:0] s [8];
      logic        exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      load_a(24'h012300, 24'h051100, 24'hF00000, 24'hF00000, 24'hF00000);
      pulse_start(1'b0);
      for (int c = 0; c < 8; c++) begin
         v[c] = bus_a.issue_valid; f[c] = bus_a.issue_func; s[c] = stall_a;
         if (c == 5) begin
            total++;
            if (bus_a.issue_rd !== 4'h5 || bus_a.issue_rs1 !== 4'h1) begin
               bad++; $display("[TB] FAIL raw_second_issue: got rd=%h rs1=%h required rd=5 rs1=1",
                               bus_a.issue_rd, bus_a.issue_rs1);
            end
         end
         @(posedge clk); #1;
      end
      for (int c = 0; c < 8; c++) begin
         total++;
         if (v[c] !== exp_v[c]) begin
            bad++; $display("[TB] FAIL raw_valid_c%0d: got %b required %b", c, v[c], exp_v[c]);
         end
      end
      total++;
      if (f[3] !== 4'hF || f[4] !== 4'hF) begin
         bad++; $display("[TB] FAIL raw_bubble_func: got %h %h required f f", f[3], f[4]);
      end
      total++;
      if (s[3] !== 16'd1 || s[4] !== 16'd2) begin
         bad++; $display("[TB] FAIL raw_stall_steps: got %0d %0d required 1 2", s[3], s[4]);
      end
      total++;
      if (stall_a !== 16'd2 || halted_a !== 1'b1) begin
         bad++; $display("[TB] FAIL raw_final: got stall=%0d halted=%b required 2/1", stall_a, halted_a);
      end
   endtask

   task automatic test_operand_use();
      logic [23:0] w [7][5] = '{
         '{24'h912340, 24'h022900, 24'hF00000, 24'hF00000, 24'hF00000},
         '{24'h012300, 24'h53A100, 24'hF00000, 24'hF00000, 24'hF00000},
         '{24'h012300, 24'h911000, 24'hF00000, 24'hF00000, 24'hF00000},
         '{24'h012300, 24'h045600, 24'h071100, 24'hF00000, 24'hF00000},
         '{24'h012300, 24'h045600, 24'h0A2B00, 24'h061100, 24'hF00000},
         '{24'h012300, 24'h4E1500, 24'hF00000, 24'hF00000, 24'hF00000},
         '{24'h012300, 24'h4E5100, 24'hF00000, 24'hF00000, 24'hF00000}};
      logic [15:0] exp_s [7] = '{16'd0, 16'd0, 16'd2, 16'd1, 16'd0, 16'd0, 16'd2};
      int n;
      for (int k = 0; k < 7; k++) begin
         do_reset();
         load_a(w[k][0], w[k][1], w[k][2], w[k][3], w[k][4]);
         pulse_start(1'b0);
         n = 0;
         while (halted_a !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         total++;
         if (halted_a !== 1'b1) begin
            bad++; $display("[TB] FAIL opuse_halt_case%0d: got halted=%b required 1", k, halted_a);
         end
         total++;
         if (stall_a !== exp_s[k]) begin
            bad++; $display("[TB] FAIL opuse_stall_case%0d: got %0d required %0d", k, stall_a, exp_s[k]);
         end
      end
   endtask

   task automatic test_wrap();
      logic       en [8];
      logic [1:0] ad [8];
      logic       v [8];
      logic [3:0] rd [8];
      logic [1:0] exp_ad [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [3:0] exp_rd [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
      rom_w[0] = 24'h01EE00; rom_w[1] = 24'h02EE00;
      rom_w[2] = 24'h03EE00; rom_w[3] = 24'h04EE00;
      do_reset();
      pulse_start(1'b1);
      for (int c = 0; c < 8; c++) begin
         en[c] = bus_w.imem_en; ad[c] = bus_w.imem_addr;
         v[c] = bus_w.issue_valid; rd[c] = bus_w.issue_rd;
         @(posedge clk); #1;
      end
      for (int c = 0; c < 6; c++) begin
         total++;
         if (en[c] !== 1'b1 || ad[c] !== exp_ad[c]) begin
            bad++; $display("[TB] FAIL wrap_fetch_c%0d: got en=%b addr=%0d required en=1 addr=%0d",
                            c, en[c], ad[c], exp_ad[c]);
         end
         total++;
         if (v[c+2] !== 1'b1 || rd[c+2] !== exp_rd[c]) begin
            bad++; $display("[TB] FAIL wrap_issue_c%0d: got valid=%b rd=%h required valid=1 rd=%h",
                            c + 2, v[c+2], rd[c+2], exp_rd[c]);
         end
      end
      do_reset();
   endtask

   task automatic test_restart();
      int n;
      do_reset();
      load_a(24'h012300, 24'h051100, 24'hF00000, 24'hF00000, 24'hF00000);
      pulse_start(1'b0);
      n = 0;
      while (halted_a !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (halted_a !== 1'b1 || stall_a !== 16'd2) begin
         bad++; $display("[TB] FAIL restart_pre: got halted=%b stall=%0d required 1/2", halted_a, stall_a);
      end
      pulse_start(1'b0);
      total++;
      if (bus_a.imem_en !== 1'b1 || bus_a.imem_addr !== 8'h00) begin
         bad++; $display("[TB] FAIL restart_fetch: got en=%b addr=%h required en=1 addr=00",
                         bus_a.imem_en, bus_a.imem_addr);
      end
      total++;
      if (stall_a !== 16'd0 || halted_a !== 1'b0) begin
         bad++; $display("[TB] FAIL restart_status: got stall=%0d halted=%b required 0/0", stall_a, halted_a);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (bus_a.issue_valid !== 1'b1 || bus_a.issue_rd !== 4'h1) begin
         bad++; $display("[TB] FAIL restart_first_issue: got valid=%b rd=%h required 1/1",
                         bus_a.issue_valid, bus_a.issue_rd);
      end
   endtask

   initial begin
      test_reset();
      test_independent();
      test_raw();
      test_operand_use();
      test_wrap();
      test_restart();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
